// File: rtl/seq_sched_pkg.sv
// Shared state encodings, defaults and helpers for the sequential-unit scheduler.
package seq_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam int DEF_NREQ = 4;
  localparam int DEF_LAT  = 3;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } abc_t;

  // Single conditional subtract: callers keep v below 2*n.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] sel_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    sel_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = rr_wrap(32'(ptr_i) + 32'(off), 32'(NREQ));
      if (!any_o && req_i[IDW'(cand)]) begin
        any_o              = 1'b1;
        idx_o              = IDW'(cand);
        sel_o[IDW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_unit_scheduler.sv
// Time-shares one 3-input sequential unit among NREQ requesters with round-robin grants.
// state | meaning
// IDLE  | unit idle, arbitrate pending requests
// CLR   | grant pulse, unit held in reset with the latched triple applied
// RUN   | unit released, triple held while the unit settles
// RESP  | response pulse with the sampled unit output
module seq_unit_scheduler
  import seq_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_abc,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_data,
  output logic              unit_a,
  output logic              unit_b,
  output logic              unit_c,
  output logic              unit_res,
  input  logic              unit_out
);

  localparam int            CW       = $clog2(LAT + 1);
  // LAT released-reset clocks for the unit to settle, plus the clock on which out is sampled.
  localparam logic [CW-1:0] RUN_LOAD = CW'(LAT);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  abc_t            abc_q, abc_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_data_q, rsp_data_d;
  abc_t            unit_abc_q, unit_abc_d;
  logic            unit_res_q, unit_res_d;

  logic [NREQ-1:0] arb_sel;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  abc_t            arb_abc;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (arb_sel),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign arb_abc = abc_t'(req_abc[3*int'(arb_idx) +: 3]);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    abc_d       = abc_q;
    id_d        = id_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unit_abc_d  = '0;
    unit_res_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d    = ST_CLR;
          gnt_d      = arb_sel;
          abc_d      = arb_abc;
          id_d       = arb_idx;
          ptr_d      = IDW'(rr_wrap(32'(arb_idx) + 32'd1, 32'(NREQ)));
          unit_res_d = 1'b1;
          unit_abc_d = arb_abc;
        end
      end
      ST_CLR: begin
        state_d    = ST_RUN;
        cnt_d      = RUN_LOAD;
        unit_abc_d = abc_q;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = unit_out;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          unit_abc_d = abc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      abc_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      unit_abc_q  <= '0;
      unit_res_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      abc_q       <= abc_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      unit_abc_q  <= unit_abc_d;
      unit_res_q  <= unit_res_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign unit_a    = unit_abc_q.a;
  assign unit_b    = unit_abc_q.b;
  assign unit_c    = unit_abc_q.c;
  assign unit_res  = unit_res_q;

endmodule

// File: tb/tb_seq_unit_scheduler.sv
// Bench for seq_unit_scheduler: behavioural sequential unit, vector table, response scoreboard.
module tb_seq_unit_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int GAP  = LAT + 4;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [3:0]  req;
  logic [11:0] req_abc;
  logic [3:0]  gnt;
  logic        busy, rsp_valid, rsp_data;
  logic [1:0]  rsp_id;
  logic        unit_a, unit_b, unit_c, unit_res, unit_out;

  seq_unit_scheduler #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .IDW  (2)
  ) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .req_abc   (req_abc),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .unit_c    (unit_c),
    .unit_res  (unit_res),
    .unit_out  (unit_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic f_model(input logic [2:0] t);
    return (t[2] & ~t[1]) | (t[1] & t[0]);
  endfunction

  // Behavioural unit: out valid only after LAT clocks out of reset, and only if the
  // triple stayed constant-valued (AND chain) over those clocks.
  logic [2:0] u_s   = '0;
  logic [1:0] u_cnt = '0;
  always @(posedge clk) begin
    if (unit_res) begin
      u_s   <= '0;
      u_cnt <= '0;
    end else begin
      u_s <= {u_s[1] & f_model({unit_a, unit_b, unit_c}),
              u_s[0] & f_model({unit_a, unit_b, unit_c}),
              f_model({unit_a, unit_b, unit_c})};
      if (u_cnt != 2'd3) u_cnt <= u_cnt + 2'd1;
    end
  end
  assign unit_out = (u_cnt == 2'd3) & u_s[2];

  typedef struct packed {
    logic [1:0] id;
    logic       data;
  } rsp_t;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] abc;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic        exp_data;
  } vec_t;

  vec_t tbl[10];
  rsp_t sb[$];
  rsp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [3:0] r, input logic [11:0] abc, input logic [1:0] id);
    vec_t v;
    v.req      = r;
    v.abc      = abc;
    v.exp_gnt  = 4'b0001 << id;
    v.exp_id   = id;
    v.exp_data = f_model(abc[3*id +: 3]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic data);
    rsp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output logic [3:0] g, output bit ok);
    g  = '0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g  = gnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (res && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %0d, expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    logic [3:0] g;
    bit         ok;
    bit         seen;
    int         last_cyc;

    req     = '0;
    req_abc = '0;
    last_cyc = 0;

    tbl[0] = mk(4'b1111, {3'b000, 3'b000, 3'b000, 3'b100}, 2'd0);
    tbl[1] = mk(4'b1111, {3'b000, 3'b000, 3'b110, 3'b000}, 2'd1);
    tbl[2] = mk(4'b1111, {3'b000, 3'b111, 3'b000, 3'b000}, 2'd2);
    tbl[3] = mk(4'b1111, {3'b010, 3'b000, 3'b000, 3'b000}, 2'd3);
    tbl[4] = mk(4'b1000, {3'b011, 3'b000, 3'b000, 3'b000}, 2'd3);
    tbl[5] = mk(4'b1000, {3'b100, 3'b000, 3'b000, 3'b000}, 2'd3);
    tbl[6] = mk(4'b0110, {3'b000, 3'b011, 3'b001, 3'b000}, 2'd1);
    tbl[7] = mk(4'b0110, {3'b000, 3'b011, 3'b001, 3'b000}, 2'd2);
    tbl[8] = mk(4'b0011, {3'b000, 3'b000, 3'b111, 3'b101}, 2'd0);
    tbl[9] = mk(4'b0011, {3'b000, 3'b000, 3'b111, 3'b101}, 2'd1);

    // Reset state
    #50;
    chk("rst_unit_res", 32'(unit_res), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_unit_abc", 32'({unit_a, unit_b, unit_c}), 32'd0);
    #47 res = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_unit_res", 32'(unit_res), 32'd0);

    // Table: rotation, single requester wrap, partial masks; req always pending
    for (int i = 0; i < 10; i++) begin
      req     = tbl[i].req;
      req_abc = tbl[i].abc;
      wait_gnt(g, ok);
      chk("tbl_gnt_seen", 32'(ok), 32'd1);
      chk("tbl_gnt", 32'(g), 32'(tbl[i].exp_gnt));
      if (ok) push_exp(tbl[i].exp_id, tbl[i].exp_data);
      if (i > 0) chk("tbl_gap", 32'(cyc - last_cyc), 32'(GAP));
      last_cyc = cyc;
    end
    req = '0;
    repeat (8) @(negedge clk);

    // Single job, exact cycle timing
    req     = 4'b0010;
    req_abc = {3'b000, 3'b000, 3'b011, 3'b000};
    push_exp(2'd1, f_model(3'b011));
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'b0010);
    chk("t2_unit_res_clr", 32'(unit_res), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_unit_abc", 32'({unit_a, unit_b, unit_c}), 32'b011);
    req = '0;
    @(negedge clk);
    chk("t2_gnt_pulse", 32'(gnt), 32'd0);
    chk("t2_unit_res_run", 32'(unit_res), 32'd0);
    repeat (3) @(negedge clk);
    chk("t2_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("t2_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // Withdrawn request while busy
    req     = 4'b0001;
    req_abc = {3'b000, 3'b000, 3'b000, 3'b011};
    wait_gnt(g, ok);
    chk("t4_gnt", 32'(g), 32'b0001);
    if (ok) push_exp(2'd0, f_model(3'b011));
    req = 4'b0100;
    repeat (2) @(negedge clk);
    req  = '0;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (gnt[2]) seen = 1'b1;
    end
    chk("t4_withdrawn", 32'(seen), 32'd0);

    // Reset in the middle of RUN
    req     = 4'b0100;
    req_abc = {3'b000, 3'b111, 3'b000, 3'b000};
    wait_gnt(g, ok);
    chk("t5_gnt", 32'(g), 32'b0100);
    req = '0;
    repeat (2) @(negedge clk);
    chk("t5_busy_run", 32'(busy), 32'd1);
    res = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_unit_res", 32'(unit_res), 32'd1);
    @(negedge clk);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    res     = 1'b1;
    req     = 4'b1001;
    req_abc = {3'b101, 3'b000, 3'b000, 3'b100};
    wait_gnt(g, ok);
    chk("t5_first_gnt", 32'(g), 32'b0001);
    if (ok) push_exp(2'd0, f_model(3'b100));
    req = 4'b1000;
    wait_gnt(g, ok);
    chk("t5_second_gnt", 32'(g), 32'b1000);
    if (ok) push_exp(2'd3, f_model(3'b101));
    req = '0;
    repeat (8) @(negedge clk);

    // Triple changes after grant must not reach the unit
    req     = 4'b0001;
    req_abc = {3'b000, 3'b000, 3'b000, 3'b100};
    wait_gnt(g, ok);
    chk("t6_gnt", 32'(g), 32'b0001);
    if (ok) push_exp(2'd0, f_model(3'b100));
    req = '0;
    @(negedge clk);
    chk("t6_abc_latched", 32'({unit_a, unit_b, unit_c}), 32'b100);
    req_abc = '0;
    repeat (2) @(negedge clk);
    chk("t6_abc_held", 32'({unit_a, unit_b, unit_c}), 32'b100);
    repeat (2) @(negedge clk);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("t6_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("t6_hold_id", 32'(rsp_id), 32'd0);
    chk("t6_hold_data", 32'(rsp_data), 32'd1);
    chk("t6_abc_cleared", 32'({unit_a, unit_b, unit_c}), 32'd0);

    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
